// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states and odd-parity helper.
// Pure declarations, no latency or flow control.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_WAIT_CLK = 3'd2,
    ST_DATA     = 3'd3,
    ST_STOP     = 3'd4,
    ST_ACK      = 3'd5,
    ST_SENT     = 3'd6,
    ST_ERROR    = 3'd7
  } ps2_state_e;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_cmd_timer.sv
// Saturating cycle counter with clear/enable; done is high once LIMIT-1 is reached.
// done is registered-count based (no extra latency), no backpressure.
module ps2_cmd_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  // Holds at all-ones rather than wrapping so a long wait can never look short.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count >= LAST);

endmodule

// File: rtl/ps2_command_out.sv
// PS/2 host-to-device command transmitter; line enables decoded from state/shift (1-cycle after update).
// send_command ignored while busy; PS2_CMD_TIMEOUT_EN adds clock-start and transfer timeouts.
module ps2_command_out
  import ps2_pkg::*;
#(
  parameter int CYCLES_INHIBIT      = 5050,
  parameter int CYCLES_CLK_TIMEOUT  = 750000,
  parameter int CYCLES_XFER_TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_posedge,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam int MAX_AB  = (CYCLES_INHIBIT > CYCLES_CLK_TIMEOUT) ? CYCLES_INHIBIT : CYCLES_CLK_TIMEOUT;
  localparam int MAX_CYC = (MAX_AB > CYCLES_XFER_TIMEOUT) ? MAX_AB : CYCLES_XFER_TIMEOUT;
  localparam int TIMER_W = $clog2(MAX_CYC) + 1;

  ps2_state_e state;
  logic [8:0] shift;
  logic [3:0] bit_idx;
  logic       inhibit_done;
  logic       clk_timeout;
  logic       xfer_timeout;
  logic       in_xfer;

  assign in_xfer = (state == ST_DATA) || (state == ST_STOP) || (state == ST_ACK);

  ps2_cmd_timer #(.WIDTH(TIMER_W), .LIMIT(CYCLES_INHIBIT)) u_inhibit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_INHIBIT),
    .enable (state == ST_INHIBIT),
    .done   (inhibit_done)
  );

`ifdef PS2_CMD_TIMEOUT_EN
  ps2_cmd_timer #(.WIDTH(TIMER_W), .LIMIT(CYCLES_CLK_TIMEOUT)) u_clk_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != ST_WAIT_CLK),
    .enable (state == ST_WAIT_CLK),
    .done   (clk_timeout)
  );

  // Measured from the first device clock, i.e. from leaving WAIT_CLK.
  ps2_cmd_timer #(.WIDTH(TIMER_W), .LIMIT(CYCLES_XFER_TIMEOUT)) u_xfer_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_xfer),
    .enable (in_xfer),
    .done   (xfer_timeout)
  );
`else
  assign clk_timeout  = 1'b0;
  assign xfer_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (send_command) begin
            shift   <= {odd_parity(the_command), the_command};
            bit_idx <= '0;
            state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inhibit_done) state <= ST_WAIT_CLK;
        end
        ST_WAIT_CLK: begin
          if (ps2_clk_negedge) begin
            bit_idx <= '0;
            state   <= ST_DATA;
          end else if (clk_timeout) begin
            state <= ST_ERROR;
          end
        end
        ST_DATA: begin
          if (xfer_timeout) begin
            state <= ST_ERROR;
          end else if (ps2_clk_negedge) begin
            if (bit_idx == 4'd8) begin
              state <= ST_STOP;
            end else begin
              shift   <= {1'b0, shift[8:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (xfer_timeout) state <= ST_ERROR;
          else if (ps2_clk_negedge) state <= ST_ACK;
        end
        ST_ACK: begin
          // A simultaneous negedge wins, so the posedge is only honoured alone.
          if (xfer_timeout) state <= ST_ERROR;
          else if (ps2_clk_posedge && !ps2_clk_negedge) state <= ps2_data ? ST_ERROR : ST_SENT;
        end
        ST_SENT, ST_ERROR: begin
          if (!send_command) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ps2_clk_drive_low  = (state == ST_INHIBIT);
  assign ps2_data_drive_low = (state == ST_INHIBIT) || (state == ST_WAIT_CLK) ||
                              ((state == ST_DATA) && !shift[0]);
  assign busy                          = (state != ST_IDLE);
  assign command_was_sent              = (state == ST_SENT);
  assign error_communication_timed_out = (state == ST_ERROR);

endmodule

// File: tb/tb_ps2_command_out.sv
// Directed bench for ps2_command_out: a PS/2 device model clocks frames out and checks each sampled bit.
module tb_ps2_command_out;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] the_command = 8'h00;
  logic       send_command = 1'b0;
  logic       ps2_clk_posedge = 1'b0;
  logic       ps2_clk_negedge = 1'b0;
  logic       ps2_data = 1'b1;
  logic       ps2_clk_drive_low;
  logic       ps2_data_drive_low;
  logic       busy;
  logic       command_was_sent;
  logic       error_communication_timed_out;

  int vectors = 0;
  int miscompares = 0;

  ps2_command_out #(
    .CYCLES_INHIBIT      (20),
    .CYCLES_CLK_TIMEOUT  (200),
    .CYCLES_XFER_TIMEOUT (100)
  ) dut (
    .clk                           (clk),
    .reset                         (reset),
    .the_command                   (the_command),
    .send_command                  (send_command),
    .ps2_clk_posedge               (ps2_clk_posedge),
    .ps2_clk_negedge               (ps2_clk_negedge),
    .ps2_data                      (ps2_data),
    .ps2_clk_drive_low             (ps2_clk_drive_low),
    .ps2_data_drive_low            (ps2_data_drive_low),
    .busy                          (busy),
    .command_was_sent              (command_was_sent),
    .error_communication_timed_out (error_communication_timed_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Model: parity by counting ones, frame = start, 8 data LSB first, odd parity, stop.
  function automatic logic model_parity(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int k = 0; k < 8; k++) ones += int'(b[k]);
    return (ones % 2) == 0;
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (i == 9) return model_parity(b);
    return 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet_window(input string name);
    int rises;
    logic prev;
    rises = 0;
    prev = ps2_clk_drive_low;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ps2_clk_drive_low && !prev) rises++;
      prev = ps2_clk_drive_low;
    end
    check({name, "_no_retransmit"}, rises, 0);
  endtask

  task automatic inhibit_phase(input logic [7:0] b, input string name);
    int hi;
    logic dl_ok;
    the_command = b;
    send_command = 1'b1;
    @(negedge clk);
    check({name, "_inhibit_start"}, ps2_clk_drive_low, 1);
    hi = 0;
    dl_ok = 1'b1;
    while (ps2_clk_drive_low && hi < 100) begin
      if (!ps2_data_drive_low) dl_ok = 1'b0;
      hi++;
      @(negedge clk);
    end
    check({name, "_inhibit_len"}, hi, 20);
    check({name, "_inhibit_data_low"}, dl_ok, 1);
  endtask

  task automatic transfer(input logic [7:0] b, input logic ack_low, input int reset_at,
                          input logic meddle, input string name);
    inhibit_phase(b, name);
    if (meddle) begin
      the_command = 8'h00;
      send_command = 1'b0;
      @(negedge clk);
      send_command = 1'b1;
    end
    check({name, "_start_bit"}, !ps2_data_drive_low, frame_bit(b, 0));
    for (int i = 1; i <= 11; i++) begin
      cyc(8);
      ps2_clk_negedge = 1'b1;
      @(negedge clk);
      ps2_clk_negedge = 1'b0;
      if (reset_at == i) begin
        cyc(3);
        check({name, "_busy_before_reset"}, busy, 1);
        reset = 1'b0;
        send_command = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check({name, "_rst_clk_dl"}, ps2_clk_drive_low, 0);
        check({name, "_rst_data_dl"}, ps2_data_drive_low, 0);
        check({name, "_rst_busy"}, busy, 0);
        check({name, "_rst_sent"}, command_was_sent, 0);
        check({name, "_rst_err"}, error_communication_timed_out, 0);
        cyc(5);
        return;
      end
      cyc(7);
      if (i <= 10) check($sformatf("%s_bit%0d", name, i), !ps2_data_drive_low, frame_bit(b, i));
      if (i == 11) ps2_data = !ack_low;
      ps2_clk_posedge = 1'b1;
      @(negedge clk);
      ps2_clk_posedge = 1'b0;
      ps2_data = 1'b1;
    end
    check({name, "_sent"}, command_was_sent, ack_low);
    check({name, "_err"}, error_communication_timed_out, !ack_low);
    check({name, "_lines_released"}, {ps2_clk_drive_low, ps2_data_drive_low}, 0);
    cyc(4);
    check({name, "_status_held"}, {busy, command_was_sent, error_communication_timed_out},
          {1'b1, ack_low, !ack_low});
    send_command = 1'b0;
    @(negedge clk);
    check({name, "_back_idle"}, {busy, command_was_sent, error_communication_timed_out}, 0);
    quiet_window(name);
  endtask

  initial begin
    logic [8:0] dl_vec;
    reset = 1'b0;
    cyc(3);
    check("reset_clk_dl", ps2_clk_drive_low, 0);
    check("reset_data_dl", ps2_data_drive_low, 0);
    check("reset_busy", busy, 0);
    check("reset_sent", command_was_sent, 0);
    check("reset_err", error_communication_timed_out, 0);
    reset = 1'b1;
    cyc(2);

    check("model_parity_ED", model_parity(8'hED), 1);
    check("model_parity_F4", model_parity(8'hF4), 0);
    for (int k = 0; k < 9; k++) dl_vec[k] = !frame_bit(8'hED, k + 1);
    check("model_dl_ED", dl_vec, 9'b000010010);
    for (int k = 0; k < 9; k++) dl_vec[k] = !frame_bit(8'hF4, k + 1);
    check("model_dl_F4", dl_vec, 9'b100001011);

    transfer(8'hED, 1'b1, 0, 1'b0, "ed");
    transfer(8'hF4, 1'b1, 0, 1'b0, "f4");
    transfer(8'hFF, 1'b0, 0, 1'b0, "ff_nak");
    transfer(8'h3C, 1'b1, 5, 1'b0, "rst");
    transfer(8'hAA, 1'b1, 0, 1'b0, "aa");
    transfer(8'hB7, 1'b1, 0, 1'b1, "meddle");

`ifdef PS2_CMD_TIMEOUT_EN
    begin
      int t;
      inhibit_phase(8'h55, "tmo");
      t = 0;
      while (!error_communication_timed_out && t < 400) begin
        @(negedge clk);
        t++;
      end
      check("tmo_cycles", t, 200);
      check("tmo_lines", {ps2_clk_drive_low, ps2_data_drive_low}, 0);
      check("tmo_sent", command_was_sent, 0);
      send_command = 1'b0;
      @(negedge clk);
      check("tmo_idle", busy, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_command_out.md
# ps2_command_out

Host-to-device PS/2 transmitter that pairs with the PS/2 data-in receiver in the keyboard/mouse interface. It sends one 8-bit command byte to the attached device: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, then a check for the device acknowledge. It drives the open-drain PS/2 lines only through active-high pull-low enables. It consumes the same synchronised clock-edge strobes and data sample as the receiver.

## Interface
Parameters:
- CYCLES_INHIBIT, 5050: clk cycles the PS/2 clock is held low before the start bit (≥100 µs at 50 MHz).
- CYCLES_CLK_TIMEOUT, 750000: maximum wait for the device to start clocking (15 ms).
- CYCLES_XFER_TIMEOUT, 100000: maximum time from the first device clock to the ack (2 ms).

Ports (clock and reset are `reset reset, synchronous, active-low; clock clk`):
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- the_command  in  8  byte to send; latched on acceptance
- send_command  in  1  level request; accepted in IDLE only
- ps2_clk_posedge  in  1  one-cycle strobe, PS/2 clock rising edge
- ps2_clk_negedge  in  1  one-cycle strobe, PS/2 clock falling edge
- ps2_data  in  1  synchronised PS/2 data line
- ps2_clk_drive_low  out  1  1 = pull PS/2 clock low
- ps2_data_drive_low  out  1  1 = pull PS/2 data low
- busy  out  1  1 in every state except IDLE
- command_was_sent  out  1  level; high in SENT
- error_communication_timed_out  out  1  level; high in ERROR

## Operation
- States:
  - IDLE: on send_command=1, latch {~^the_command, the_command} into a 9-bit shift register, clear the timer, go to INHIBIT.
  - INHIBIT: clock and data both driven low. Go to WAIT_CLK once the timer reaches CYCLES_INHIBIT-1, and clear the timer.
  - WAIT_CLK: clock released; data held low (start bit). On ps2_clk_negedge go to DATA with bit index 0.
  - DATA: ps2_data_drive_low = ~shift[0]. On each negedge, shift right and increment the index. A negedge at index 8 goes to STOP.
  - STOP: data released (stop bit = 1). On negedge go to ACK.
  - ACK: on posedge, ps2_data=0 goes to SENT; ps2_data=1 goes to ERROR.
  - SENT / ERROR: hold until send_command=0, then go to IDLE.
- Parity is odd: bit 9 = ~^data.
- send_command while busy is ignored. the_command changes after acceptance have no effect.
- A posedge and a negedge strobe in the same cycle cannot occur. If they do, the negedge takes priority.
- Reset in any state: IDLE next cycle, both drive-lows 0, all status outputs 0.
- Reset values: ps2_clk_drive_low=0, ps2_data_drive_low=0, busy=0, command_was_sent=0, error_communication_timed_out=0.
- Unused state encodings recover to IDLE.

## Timing
- All outputs are registered, or decoded from the state register only. The lines change the cycle after a state or shift update.
- ps2_clk_drive_low is high for exactly CYCLES_INHIBIT cycles.
- ps2_data_drive_low rises with ps2_clk_drive_low and stays high through WAIT_CLK.
- Data bits change the cycle after each negedge strobe; the device samples them on the following posedge.
- command_was_sent rises the cycle after the ack posedge.
- The timer width is $clog2 of the largest parameter value, plus 1. The timer saturates and never wraps.

## Configuration
- Macro PS2_CMD_TIMEOUT_EN.
- Defined:
  - WAIT_CLK goes to ERROR after CYCLES_CLK_TIMEOUT cycles without a negedge.
  - DATA, STOP and ACK go to ERROR once CYCLES_XFER_TIMEOUT cycles have elapsed since leaving WAIT_CLK.
  - On timeout, both lines are released immediately.
- Undefined:
  - No timeout counters are built, and the FSM waits indefinitely.
  - ERROR is reachable only through a bad ack (data high).

## Structure
- Shared package ps2_pkg holds the state enum and an odd-parity function.
- Sub-module ps2_cmd_timer provides the saturating cycle counter, with clear/enable and compare against a parameter.

## Test plan
Bench uses CYCLES_INHIBIT=20, CYCLES_CLK_TIMEOUT=200, CYCLES_XFER_TIMEOUT=100 and a device model toggling the clock every 8 cycles.
- Send 0xED: clock low for 20 cycles; data_drive_low sequence over the 9 bits 0,1,0,0,1,0,0,0,0 (parity 1); device acks low -> command_was_sent=1 until send_command=0.
- Send 0xF4: parity bit 0, so the 9th bit is data_drive_low=1; ack -> sent.
- Send 0xFF with the device holding data high at ack -> error_communication_timed_out=1, command_was_sent=0.
- With PS2_CMD_TIMEOUT_EN defined and no device clock: ERROR 200 cycles after WAIT_CLK entry, both drive-lows 0.
- Assert reset while in DATA at bit 4 -> next cycle IDLE, all outputs 0. A new send of 0xAA then completes correctly.
- Change the_command to 0x00 and pulse send_command again while busy -> the transmitted bits still match the original byte, with exactly one transfer.
